// File: rtl/data_memory_param.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_param
// Brief    : Byte-strobed single-port-read/single-port-write data memory with
//            a zeroing sweep after reset and out-of-range access flagging.
//            Optional macro DATA_MEMORY_PARAM_BYPASS_EN forwards a same-cycle
//            same-address write into the read result.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_enable,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_valid,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] write_strb,
  output logic                busy,
  output logic                addr_err
);

  localparam int c_NB    = DATA_W / 8;
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]    c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_IDX_W-1:0] c_LAST_PTR  = c_IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [c_IDX_W-1:0]  clear_ptr_q;
  logic [DATA_W-1:0]   read_data_q;
  logic                read_valid_q;
  logic                addr_err_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                rd_in_range;
  logic                wr_in_range;
  logic                wr_ok;
  logic [c_IDX_W-1:0]  rd_idx;
  logic [c_IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0]   read_data_d;

  assign rd_in_range = ({1'b0, read_addr}  < c_DEPTH_EXT);
  assign wr_in_range = ({1'b0, write_addr} < c_DEPTH_EXT);
  assign rd_idx      = read_addr[c_IDX_W-1:0];
  assign wr_idx      = write_addr[c_IDX_W-1:0];
  assign wr_ok       = (state_q == S_READY) && write_enable && wr_in_range;

  always_comb begin
    read_data_d = mem_q[rd_idx];
`ifdef DATA_MEMORY_PARAM_BYPASS_EN
    if (wr_ok && (rd_idx == wr_idx)) begin
      for (int b = 0; b < c_NB; b++) begin
        if (write_strb[b]) read_data_d[8*b +: 8] = write_data[8*b +: 8];
      end
    end
`endif
    // Out-of-range reads return zero rather than an aliased word.
    if (!rd_in_range) read_data_d = '0;
  end

  // Storage carries no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem_q[clear_ptr_q] <= '0;
      end else if (wr_ok) begin
        for (int b = 0; b < c_NB; b++) begin
          if (write_strb[b]) mem_q[wr_idx][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clear_ptr_q  <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          read_valid_q <= 1'b0;
          addr_err_q   <= 1'b0;
          if (clear_ptr_q == c_LAST_PTR) begin
            clear_ptr_q <= '0;
            state_q     <= S_READY;
          end else begin
            clear_ptr_q <= clear_ptr_q + 1'b1;
          end
        end
        default: begin
          read_valid_q <= read_enable;
          if (read_enable) read_data_q <= read_data_d;
          addr_err_q   <= (read_enable && !rd_in_range) ||
                          (write_enable && !wr_in_range);
        end
      endcase
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = (state_q == S_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_param
// Brief    : Directed scoreboard bench for data_memory_param (DEPTH=16, 16-bit
//            words); honours DATA_MEMORY_PARAM_BYPASS_EN for collision results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_param;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 16;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read_enable = 1'b0;
  logic [ADDR_W-1:0] read_addr = '0;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              write_enable = 1'b0;
  logic [ADDR_W-1:0] write_addr = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic [NB-1:0]     write_strb = '0;
  logic              busy;
  logic              addr_err;

  always #5 clk = ~clk;

  data_memory_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .read_enable(read_enable), .read_addr(read_addr),
    .read_data(read_data), .read_valid(read_valid),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .write_strb(write_strb),
    .busy(busy), .addr_err(addr_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                clear_cnt = 0;
  logic              exp_valid = 1'b0;
  logic              exp_err   = 1'b0;
  logic [DATA_W-1:0] last_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict from the inputs in place, advance one edge, then compare.
  task automatic cycle(input string tag);
    logic [DATA_W-1:0] w;
    logic rd_in, wr_in;
    rd_in = (read_addr < DEPTH);
    wr_in = (write_addr < DEPTH);
    if (rst) begin
      clear_cnt = DEPTH;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      last_data = '0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (clear_cnt > 0) begin
      clear_cnt--;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_valid = read_enable;
      exp_err   = (read_enable && !rd_in) || (write_enable && !wr_in);
      if (read_enable) begin
        w = rd_in ? model_mem[read_addr] : '0;
`ifdef DATA_MEMORY_PARAM_BYPASS_EN
        if (rd_in && write_enable && wr_in && (read_addr == write_addr))
          for (int b = 0; b < NB; b++)
            if (write_strb[b]) w[8*b +: 8] = write_data[8*b +: 8];
`endif
        exp_q.push_back(w);
      end
      if (write_enable && wr_in)
        for (int b = 0; b < NB; b++)
          if (write_strb[b]) model_mem[write_addr][8*b +: 8] = write_data[8*b +: 8];
    end
    @(posedge clk);
    #1;
    chk({tag, " busy"}, 64'(busy), 64'(clear_cnt > 0));
    chk({tag, " read_valid"}, 64'(read_valid), 64'(exp_valid));
    chk({tag, " addr_err"}, 64'(addr_err), 64'(exp_err));
    if (read_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL %s unexpected_read: observed=valid expected=none", tag);
      end
      if (exp_q.size() != 0) begin
        last_data = exp_q.pop_front();
        chk({tag, " read_data"}, 64'(read_data), 64'(last_data));
      end
    end else begin
      chk({tag, " read_data_hold"}, 64'(read_data), 64'(last_data));
    end
  endtask

  task automatic idle(input string tag);
    read_enable = 1'b0; write_enable = 1'b0;
    cycle(tag);
  endtask

  task automatic wr(input string tag, input int a, input logic [DATA_W-1:0] d, input logic [NB-1:0] s);
    write_enable = 1'b1; write_addr = ADDR_W'(a); write_data = d; write_strb = s;
    read_enable = 1'b0;
    cycle(tag);
    write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input int a);
    read_enable = 1'b1; read_addr = ADDR_W'(a);
    write_enable = 1'b0;
    cycle(tag);
    read_enable = 1'b0;
  endtask

  task automatic wrrd(input string tag, input int wa, input logic [DATA_W-1:0] d,
                      input logic [NB-1:0] s, input int ra);
    write_enable = 1'b1; write_addr = ADDR_W'(wa); write_data = d; write_strb = s;
    read_enable  = 1'b1; read_addr  = ADDR_W'(ra);
    cycle(tag);
    write_enable = 1'b0; read_enable = 1'b0;
  endtask

  initial begin
    // Reset and full sweep
    rst = 1'b1; cycle("reset"); rst = 1'b0;
    repeat (DEPTH) idle("sweep");
    for (int a = 0; a < DEPTH; a++) rd("sweep_zero", a);
    idle("sweep_drain");

    // Byte strobes
    wr("strb_full", 5, 16'hABCD, 2'b11);
    wr("strb_low", 5, 16'h1234, 2'b01);
    rd("strb_read", 5);
    wr("strb_high", 6, 16'h5678, 2'b10);
    rd("strb_high_read", 6);
    idle("strb_drain");

    // Out-of-range write and read, then confirm nothing in range moved
    wr("oor_write", 20, 16'hFFFF, 2'b11);
    idle("oor_gap");
    rd("oor_read", 20);
    rd("oor_max_addr", 16'hFFFF);
    wr("oor_edge_write", DEPTH, 16'hFFFF, 2'b11);
    for (int a = 0; a < DEPTH; a++) rd("oor_scan", a);
    idle("oor_drain");

    // Same-address collisions (full and partial strobe)
    wr("col_init", 3, 16'h1111, 2'b11);
    wrrd("col_full", 3, 16'h2222, 2'b11, 3);
    rd("col_after", 3);
    wrrd("col_partial", 3, 16'h3344, 2'b01, 3);
    rd("col_partial_after", 3);

    // Different-address simultaneous access
    wrrd("diff_addr", 7, 16'h7777, 2'b11, 5);
    rd("diff_addr_after", 7);

    // Idle hold of read_data
    wr("hold_init", 2, 16'h00AA, 2'b11);
    rd("hold_read", 2);
    repeat (3) idle("hold_idle");

    // Reset mid-operation discards an in-flight read
    read_enable = 1'b1; read_addr = ADDR_W'(5); rst = 1'b1;
    cycle("rst_inflight");
    rst = 1'b0; read_enable = 1'b0;

    // Reset again at sweep cycle 7, with a write attempted while busy
    repeat (6) idle("sweep_a");
    rst = 1'b1; cycle("rst_mid_sweep"); rst = 1'b0;
    repeat (4) idle("sweep_b");
    wr("busy_write", 4, 16'hBEEF, 2'b11);
    rd("busy_read", 4);
    repeat (DEPTH - 6) idle("sweep_c");
    for (int a = 0; a < DEPTH; a++) rd("resweep_zero", a);
    idle("final_drain");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
